// File: rtl/carry_skip_adder_seq_if.sv
`default_nettype none
// ============================================================================
// Module   : carry_skip_adder_seq_if
// Purpose  : Operand/result handshake bundle for carry_skip_adder_seq.
//            Carries the valid/ready pair on the operand side (a, b, cin)
//            and on the result side (sum, cout, optional skip_cnt).
// Ports    : master modport -> operand source / result sink
//            slave  modport -> the adder itself
// Config   : SKIP_CNT_EN adds the skip_cnt signal (skipped-group count)
// Revision : 1.0 - initial release
// ============================================================================
interface carry_skip_adder_seq_if #(
  parameter int WIDTH = 16,
  parameter int BLOCK = 4
);
  localparam int c_NBLK = WIDTH / BLOCK;
  localparam int c_SKW  = $clog2(c_NBLK + 1);

  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             cin;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] sum;
  logic             cout;
`ifdef SKIP_CNT_EN
  logic [c_SKW-1:0] skip_cnt;
`endif

  modport master (
    output in_valid, a, b, cin, out_ready,
`ifdef SKIP_CNT_EN
    input  skip_cnt,
`endif
    input  in_ready, out_valid, sum, cout
  );

  modport slave (
    input  in_valid, a, b, cin, out_ready,
`ifdef SKIP_CNT_EN
    output skip_cnt,
`endif
    output in_ready, out_valid, sum, cout
  );
endinterface
`default_nettype wire

// File: rtl/carry_skip_adder_seq.sv
`default_nettype none
// ============================================================================
// Module   : carry_skip_adder_seq
// Purpose  : Block-serial carry-skip adder. WIDTH-bit operands are split into
//            BLOCK-bit groups and one group is resolved per clock using a
//            ripple sum plus a propagate-skip mux on the group carry.
// Ports    : clk  - clock, rising edge
//            rst  - synchronous reset, active-high
//            bus  - carry_skip_adder_seq_if.slave
//                   in_valid/in_ready, a, b, cin   (operand side)
//                   out_valid/out_ready, sum, cout (result side)
//                   skip_cnt                       (SKIP_CNT_EN only)
// Config   : `define SKIP_CNT_EN to count groups whose carry was skipped
// Revision : 1.0 - initial release
// ============================================================================
module carry_skip_adder_seq #(
  parameter int WIDTH = 16,
  parameter int BLOCK = 4
) (
  input  wire                        clk,
  input  wire                        rst,
  carry_skip_adder_seq_if.slave      bus
);

  localparam int c_NBLK = WIDTH / BLOCK;
  localparam int c_IDXW = (c_NBLK > 1) ? $clog2(c_NBLK) : 1;
`ifdef SKIP_CNT_EN
  localparam int c_SKW  = $clog2(c_NBLK + 1);
`endif
  localparam logic [c_IDXW-1:0] c_LAST = c_IDXW'(c_NBLK - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_ADD  = 2'd1,
    S_HOLD = 2'd2
  } state_t;

  state_t            r_state;
  state_t            w_state_nxt;
  logic              w_in_ready;
  logic              w_capture;
  logic              w_last;

  logic [WIDTH-1:0]  r_a;
  logic [WIDTH-1:0]  r_b;
  logic              r_carry;
  logic [c_IDXW-1:0] r_idx;
  logic [WIDTH-1:0]  r_sum;
  logic              r_cout;
  logic              r_out_valid;
`ifdef SKIP_CNT_EN
  logic [c_SKW-1:0]  r_skip_cnt;
`endif

  logic [BLOCK-1:0]  w_ga;
  logic [BLOCK-1:0]  w_gb;
  logic [BLOCK-1:0]  w_gs;
  logic [BLOCK:0]    w_rc;
  logic              w_p;
  logic              w_carry_nxt;

  // Select the active group of the captured operands.
  always_comb begin
    w_ga = '0;
    w_gb = '0;
    for (int k = 0; k < c_NBLK; k++) begin
      if (r_idx == c_IDXW'(k)) begin
        w_ga = r_a[k*BLOCK +: BLOCK];
        w_gb = r_b[k*BLOCK +: BLOCK];
      end
    end
  end

  // Ripple through the group; w_rc[i] is the carry into bit i.
  always_comb begin
    w_rc    = '0;
    w_gs    = '0;
    w_rc[0] = r_carry;
    for (int i = 0; i < BLOCK; i++) begin
      w_gs[i]   = w_ga[i] ^ w_gb[i] ^ w_rc[i];
      w_rc[i+1] = (w_ga[i] & w_gb[i]) | (w_rc[i] & (w_ga[i] ^ w_gb[i]));
    end
  end

  // A fully propagating group passes its incoming carry straight through.
  assign w_p         = &(w_ga ^ w_gb);
  assign w_carry_nxt = w_p ? r_carry : w_rc[BLOCK];
  assign w_last      = (r_idx == c_LAST);

  // Next-state and handshake decode.
  always_comb begin
    w_state_nxt = r_state;
    w_in_ready  = 1'b0;
    w_capture   = 1'b0;
    case (r_state)
      S_IDLE: begin
        w_in_ready = 1'b1;
        if (bus.in_valid) begin
          w_capture   = 1'b1;
          w_state_nxt = S_ADD;
        end
      end
      S_ADD: begin
        if (w_last) w_state_nxt = S_HOLD;
      end
      S_HOLD: begin
        // Accepting a new operand set in the same cycle the result drains
        // keeps back-to-back operations free of bubbles.
        w_in_ready = bus.out_ready;
        if (bus.out_ready) begin
          w_capture   = bus.in_valid;
          w_state_nxt = bus.in_valid ? S_ADD : S_IDLE;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
    if (rst) begin
      w_in_ready = 1'b0;
      w_capture  = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_a         <= '0;
      r_b         <= '0;
      r_carry     <= 1'b0;
      r_idx       <= '0;
      r_sum       <= '0;
      r_cout      <= 1'b0;
      r_out_valid <= 1'b0;
`ifdef SKIP_CNT_EN
      r_skip_cnt  <= '0;
`endif
    end else if (w_capture) begin
      r_a         <= bus.a;
      r_b         <= bus.b;
      r_carry     <= bus.cin;
      r_idx       <= '0;
      r_out_valid <= 1'b0;
`ifdef SKIP_CNT_EN
      r_skip_cnt  <= '0;
`endif
    end else if (r_state == S_ADD) begin
      for (int k = 0; k < c_NBLK; k++) begin
        if (r_idx == c_IDXW'(k)) r_sum[k*BLOCK +: BLOCK] <= w_gs;
      end
      r_carry <= w_carry_nxt;
`ifdef SKIP_CNT_EN
      r_skip_cnt <= r_skip_cnt + c_SKW'(w_p);
`endif
      if (w_last) begin
        r_idx       <= '0;
        r_cout      <= w_carry_nxt;
        r_out_valid <= 1'b1;
      end else begin
        r_idx <= r_idx + c_IDXW'(1);
      end
    end else if (r_state == S_HOLD && bus.out_ready) begin
      r_out_valid <= 1'b0;
    end
  end

  assign bus.in_ready  = w_in_ready;
  assign bus.out_valid = r_out_valid;
  assign bus.sum       = r_sum;
  assign bus.cout      = r_cout;
`ifdef SKIP_CNT_EN
  assign bus.skip_cnt  = r_skip_cnt;
`endif

endmodule
`default_nettype wire
